// File: rtl/exe_hazard_ctrl_pkg.sv
// Shared types for the execute-stage hazard controller: forwarding encodings,
// FSM states, the shadow-entry layout and the stage/register match helper.
package exe_hazard_ctrl_pkg;

   localparam int HAZ_REG_W = 4;

   localparam logic [1:0] FWD_REG   = 2'b00;
   localparam logic [1:0] FWD_EXMEM = 2'b01;
   localparam logic [1:0] FWD_MEMWB = 2'b10;

   typedef enum logic {
      RUN     = 1'b0,
      LU_WAIT = 1'b1
   } haz_state_t;

   typedef struct packed {
      logic                 valid;
      logic                 wr;
      logic                 is_load;
      logic [HAZ_REG_W-1:0] dest;
      logic [HAZ_REG_W-1:0] rs;
      logic [HAZ_REG_W-1:0] rt;
   } shadow_t;

   // A stage hazards a source when it will write that register; r0 is exempt when hardwired.
   function automatic logic haz_match(input shadow_t s, input logic [HAZ_REG_W-1:0] idx,
                                      input logic zero_reg);
      return s.valid & s.wr & (s.dest == idx) & ~(zero_reg & (idx == '0));
   endfunction

endpackage

// File: rtl/exe_hazard_ctrl_shadow_stage.sv
// One pipeline shadow register: holds while frozen, loads an all-zero bubble when
// killed, otherwise captures the upstream entry.
module haz_shadow_stage
   import exe_hazard_ctrl_pkg::*;
(
   input  logic    clk,
   input  logic    rst,
   input  logic    hold,
   input  logic    kill,
   input  shadow_t d,
   output shadow_t q
);

   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         q <= '0;
      else if (!hold)
         q <= kill ? '0 : d;
   end

endmodule

// File: rtl/exe_hazard_ctrl.sv
// Execute-stage hazard controller: operand forwarding selects and load-use stall/bubble.
// Optional HAZ_PERF_EN adds stall/bubble performance counters.
module exe_hazard_ctrl
   import exe_hazard_ctrl_pkg::*;
#(
   // REG_W must equal the package shadow-entry width HAZ_REG_W.
   parameter int REG_W    = HAZ_REG_W,
   parameter bit ZERO_REG = 1'b1
)(
   input  logic             clk,
   input  logic             rst,
   input  logic             id_valid,
   input  logic [REG_W-1:0] id_rs,
   input  logic             id_uses_rs,
   input  logic [REG_W-1:0] id_rt,
   input  logic             id_uses_rt,
   input  logic [REG_W-1:0] id_dest,
   input  logic             id_wr,
   input  logic             id_is_load,
   input  logic             flush,
   input  logic             mem_wait,
   output logic             stall_o,
   output logic             bubble_o,
   output logic [1:0]       fwd_a_sel,
   output logic [1:0]       fwd_b_sel
`ifdef HAZ_PERF_EN
   ,
   output logic [31:0]      perf_stall_cnt,
   output logic [31:0]      perf_bubble_cnt
`endif
);

   shadow_t    id_entry, ex_q, mem_q, wb_q;
   haz_state_t state_q, state_d;
   logic       issue, load_use;

   assign id_entry = '{valid: id_valid, wr: id_wr, is_load: id_is_load,
                       dest: id_dest, rs: id_rs, rt: id_rt};
   assign issue    = id_valid & ~stall_o & ~flush;

   haz_shadow_stage u_ex  (.clk(clk), .rst(rst), .hold(mem_wait), .kill(~issue),
                           .d(id_entry), .q(ex_q));
   haz_shadow_stage u_mem (.clk(clk), .rst(rst), .hold(mem_wait), .kill(1'b0),
                           .d(ex_q), .q(mem_q));
   haz_shadow_stage u_wb  (.clk(clk), .rst(rst), .hold(mem_wait), .kill(1'b0),
                           .d(mem_q), .q(wb_q));

   assign load_use = id_valid & ex_q.is_load &
                     ((haz_match(ex_q, id_rs, ZERO_REG) & id_uses_rs) |
                      (haz_match(ex_q, id_rt, ZERO_REG) & id_uses_rt));

   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         state_q <= RUN;
      else
         state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      if (!mem_wait) begin
         if (flush)
            state_d = RUN;
         else begin
            case (state_q)
               RUN:     if (load_use) state_d = LU_WAIT;
               LU_WAIT: state_d = RUN;
               default: state_d = RUN;
            endcase
         end
      end
   end

   // Outputs are forced quiet while reset is asserted, whatever the inputs do.
   always_comb begin
      stall_o  = 1'b0;
      bubble_o = 1'b0;
      if (rst) begin
         stall_o  = 1'b0;
         bubble_o = 1'b0;
      end else if (mem_wait) begin
         stall_o = 1'b1;
      end else if (flush) begin
         bubble_o = 1'b1;
      end else if (state_q == RUN && load_use) begin
         stall_o  = 1'b1;
         bubble_o = 1'b1;
      end
   end

   always_comb begin
      fwd_a_sel = FWD_REG;
      if (haz_match(mem_q, ex_q.rs, ZERO_REG))
         fwd_a_sel = FWD_EXMEM;
      else if (haz_match(wb_q, ex_q.rs, ZERO_REG))
         fwd_a_sel = FWD_MEMWB;

      fwd_b_sel = FWD_REG;
      if (haz_match(mem_q, ex_q.rt, ZERO_REG))
         fwd_b_sel = FWD_EXMEM;
      else if (haz_match(wb_q, ex_q.rt, ZERO_REG))
         fwd_b_sel = FWD_MEMWB;
   end

`ifdef HAZ_PERF_EN
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         perf_stall_cnt  <= '0;
         perf_bubble_cnt <= '0;
      end else begin
         if (stall_o)
            perf_stall_cnt <= perf_stall_cnt + 32'd1;
         if (bubble_o)
            perf_bubble_cnt <= perf_bubble_cnt + 32'd1;
      end
   end
`endif

endmodule
